// File: rtl/tage_update_ctrl_if.sv
// Commit-record and table write-port bundle for tage_update_ctrl.
// The slave side is the controller; the master side is the commit stage plus the tables.
interface tage_update_ctrl_if #(
    parameter int unsigned NUM_TABLES       = 4,
    parameter int unsigned PHT_DEPTH        = 2048,
    parameter int unsigned PHT_TAG_WIDTH    = 11,
    parameter int unsigned PHT_CTR_WIDTH    = 2,
    parameter int unsigned PHT_USEFUL_WIDTH = 3
);
    localparam int unsigned IDX_W  = $clog2(PHT_DEPTH);
    localparam int unsigned PROV_W = $clog2(NUM_TABLES + 1);

    logic                                   commit_valid_i;
    logic                                   commit_ready_o;
    logic                                   commit_taken_i;
    logic                                   commit_mispredict_i;
    logic [PROV_W-1:0]                      commit_provider_i;
    logic                                   commit_provider_taken_i;
    logic                                   commit_alt_taken_i;
    logic [NUM_TABLES*PHT_CTR_WIDTH-1:0]    commit_ctr_i;
    logic [NUM_TABLES*PHT_USEFUL_WIDTH-1:0] commit_useful_i;
    logic [NUM_TABLES*PHT_TAG_WIDTH-1:0]    commit_query_tag_i;
    logic [NUM_TABLES*PHT_TAG_WIDTH-1:0]    commit_origin_tag_i;
    logic [NUM_TABLES*IDX_W-1:0]            commit_index_i;
    logic                                   update_stall_i;
    logic [NUM_TABLES-1:0]                  update_valid_o;
    logic [NUM_TABLES-1:0]                  update_useful_o;
    logic [NUM_TABLES-1:0]                  inc_useful_o;
    logic [NUM_TABLES-1:0]                  update_ctr_o;
    logic [NUM_TABLES-1:0]                  inc_ctr_o;
    logic [NUM_TABLES-1:0]                  realloc_entry_o;
    logic [NUM_TABLES*PHT_USEFUL_WIDTH-1:0] update_useful_bits_o;
    logic [NUM_TABLES*PHT_CTR_WIDTH-1:0]    update_ctr_bits_o;
    logic [NUM_TABLES*PHT_TAG_WIDTH-1:0]    update_tag_o;
    logic [NUM_TABLES*IDX_W-1:0]            update_index_o;

    modport master (
        output commit_valid_i, commit_taken_i, commit_mispredict_i, commit_provider_i,
               commit_provider_taken_i, commit_alt_taken_i, commit_ctr_i, commit_useful_i,
               commit_query_tag_i, commit_origin_tag_i, commit_index_i, update_stall_i,
        input  commit_ready_o, update_valid_o, update_useful_o, inc_useful_o, update_ctr_o,
               inc_ctr_o, realloc_entry_o, update_useful_bits_o, update_ctr_bits_o,
               update_tag_o, update_index_o
    );

    modport slave (
        input  commit_valid_i, commit_taken_i, commit_mispredict_i, commit_provider_i,
               commit_provider_taken_i, commit_alt_taken_i, commit_ctr_i, commit_useful_i,
               commit_query_tag_i, commit_origin_tag_i, commit_index_i, update_stall_i,
        output commit_ready_o, update_valid_o, update_useful_o, inc_useful_o, update_ctr_o,
               inc_ctr_o, realloc_entry_o, update_useful_bits_o, update_ctr_bits_o,
               update_tag_o, update_index_o
    );
endinterface

// File: rtl/tage_update_ctrl.sv
// TAGE update controller: buffers commit records and drives per-table write controls.
// Optional macro TAGE_UPDATE_FWD_EN adds per-table last-write forwarding of ctr/useful.
module tage_update_ctrl #(
    parameter int unsigned NUM_TABLES       = 4,
    parameter int unsigned PHT_DEPTH        = 2048,
    parameter int unsigned PHT_TAG_WIDTH    = 11,
    parameter int unsigned PHT_CTR_WIDTH    = 2,
    parameter int unsigned PHT_USEFUL_WIDTH = 3,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input logic           clk,
    input logic           rst,
    tage_update_ctrl_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(PHT_DEPTH);
    localparam int unsigned PROV_W = $clog2(NUM_TABLES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = PHT_CTR_WIDTH;
    localparam int unsigned UW     = PHT_USEFUL_WIDTH;
    localparam int unsigned TW     = PHT_TAG_WIDTH;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic                         taken;
        logic                         mispredict;
        logic [PROV_W-1:0]            provider;
        logic                         provider_taken;
        logic                         alt_taken;
        logic [NUM_TABLES*CW-1:0]     ctr;
        logic [NUM_TABLES*UW-1:0]     useful;
        logic [NUM_TABLES*TW-1:0]     query_tag;
        logic [NUM_TABLES*TW-1:0]     origin_tag;
        logic [NUM_TABLES*IDX_W-1:0]  index;
    } rec_t;

    rec_t                     fifo_q [FIFO_DEPTH];
    rec_t                     fifo_d [FIFO_DEPTH];
    rec_t                     in_rec;
    rec_t                     head;
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                     ready_q, ready_d;
    logic                     push, pop;
    logic [7:0]               lfsr_q, lfsr_d;

    logic [NUM_TABLES-1:0]    update_valid_q, update_valid_d;
    logic [NUM_TABLES-1:0]    update_useful_q, update_useful_d;
    logic [NUM_TABLES-1:0]    inc_useful_q, inc_useful_d;
    logic [NUM_TABLES-1:0]    update_ctr_q, update_ctr_d;
    logic [NUM_TABLES-1:0]    inc_ctr_q, inc_ctr_d;
    logic [NUM_TABLES-1:0]    realloc_q, realloc_d;
    logic [NUM_TABLES*UW-1:0] useful_bits_q, useful_bits_d;
    logic [NUM_TABLES*CW-1:0] ctr_bits_q, ctr_bits_d;
    logic [NUM_TABLES*TW-1:0] tag_q, tag_d;
    logic [NUM_TABLES*IDX_W-1:0] index_q, index_d;

    logic [NUM_TABLES-1:0][CW-1:0] ctr_m;
    logic [NUM_TABLES-1:0][UW-1:0] useful_m;
    int unsigned              prov, ncand, first_c, second_c, chosen;
    logic                     alloc, alloc_fail;

`ifdef TAGE_UPDATE_FWD_EN
    localparam logic [CW-1:0] CTR_REALLOC = {1'b1, {(CW-1){1'b0}}};

    logic [NUM_TABLES-1:0]             fwd_valid_q, fwd_valid_d;
    logic [NUM_TABLES-1:0][IDX_W-1:0]  fwd_idx_q, fwd_idx_d;
    logic [NUM_TABLES-1:0][CW-1:0]     fwd_ctr_q, fwd_ctr_d;
    logic [NUM_TABLES-1:0][UW-1:0]     fwd_useful_q, fwd_useful_d;

    function automatic logic [CW-1:0] sat_ctr(input logic [CW-1:0] v, input logic inc);
        if (inc) return (&v) ? v : v + CW'(1);
        return (v == '0) ? v : v - CW'(1);
    endfunction

    function automatic logic [UW-1:0] sat_useful(input logic [UW-1:0] v, input logic inc);
        if (inc) return (&v) ? v : v + UW'(1);
        return (v == '0) ? v : v - UW'(1);
    endfunction
`endif

    always_comb begin
        in_rec.taken          = bus.commit_taken_i;
        in_rec.mispredict     = bus.commit_mispredict_i;
        in_rec.provider       = bus.commit_provider_i;
        in_rec.provider_taken = bus.commit_provider_taken_i;
        in_rec.alt_taken      = bus.commit_alt_taken_i;
        in_rec.ctr            = bus.commit_ctr_i;
        in_rec.useful         = bus.commit_useful_i;
        in_rec.query_tag      = bus.commit_query_tag_i;
        in_rec.origin_tag     = bus.commit_origin_tag_i;
        in_rec.index          = bus.commit_index_i;

        push = bus.commit_valid_i && ready_q;
        pop  = (wr_ptr_q != rd_ptr_q) && !bus.update_stall_i;
        head = fifo_q[rd_ptr_q[PTR_W-1:0]];

        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q[PTR_W-1:0]] = in_rec;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        ready_d  = (wr_ptr_d - rd_ptr_d) != FULL_CNT;
    end

    // Effective per-table meta (possibly forwarded) and allocation victim choice.
    always_comb begin
        prov = 32'(head.provider);
        for (int unsigned t = 0; t < NUM_TABLES; t++) begin
            ctr_m[t]    = head.ctr[t*CW +: CW];
            useful_m[t] = head.useful[t*UW +: UW];
`ifdef TAGE_UPDATE_FWD_EN
            if (fwd_valid_q[t] && fwd_idx_q[t] == head.index[t*IDX_W +: IDX_W]) begin
                ctr_m[t]    = fwd_ctr_q[t];
                useful_m[t] = fwd_useful_q[t];
            end
`endif
        end
        ncand    = 0;
        first_c  = 0;
        second_c = 0;
        for (int unsigned t = 0; t < NUM_TABLES; t++) begin
            if (head.mispredict && prov < NUM_TABLES && t >= prov && useful_m[t] == '0) begin
                if (ncand == 0)      first_c  = t;
                else if (ncand == 1) second_c = t;
                ncand++;
            end
        end
        alloc      = ncand != 0;
        alloc_fail = head.mispredict && prov < NUM_TABLES && ncand == 0;
        chosen     = (ncand >= 2 && lfsr_q[0]) ? second_c : first_c;
    end

    always_comb begin
        update_valid_d  = '0;
        update_useful_d = '0;
        inc_useful_d    = '0;
        update_ctr_d    = '0;
        inc_ctr_d       = '0;
        realloc_d       = '0;
        useful_bits_d   = '0;
        ctr_bits_d      = '0;
        tag_d           = '0;
        index_d         = '0;
        lfsr_d          = lfsr_q;
        if (pop) begin
            // Table t+1 is the provider, the allocation victim, or a decay target -- never two of these.
            for (int unsigned t = 0; t < NUM_TABLES; t++) begin
                if (prov == t + 1) begin
                    update_valid_d[t]            = 1'b1;
                    update_ctr_d[t]              = 1'b1;
                    inc_ctr_d[t]                 = head.taken;
                    ctr_bits_d[t*CW +: CW]       = ctr_m[t];
                    useful_bits_d[t*UW +: UW]    = useful_m[t];
                    tag_d[t*TW +: TW]            = head.query_tag[t*TW +: TW];
                    index_d[t*IDX_W +: IDX_W]    = head.index[t*IDX_W +: IDX_W];
                    if (head.provider_taken != head.alt_taken) begin
                        update_useful_d[t] = 1'b1;
                        inc_useful_d[t]    = head.provider_taken == head.taken;
                    end
                end else if (alloc && chosen == t) begin
                    update_valid_d[t]            = 1'b1;
                    realloc_d[t]                 = 1'b1;
                    ctr_bits_d[t*CW +: CW]       = ctr_m[t];
                    useful_bits_d[t*UW +: UW]    = useful_m[t];
                    tag_d[t*TW +: TW]            = head.query_tag[t*TW +: TW];
                    index_d[t*IDX_W +: IDX_W]    = head.index[t*IDX_W +: IDX_W];
                end else if (alloc_fail && t >= prov) begin
                    update_valid_d[t]            = 1'b1;
                    update_useful_d[t]           = 1'b1;
                    ctr_bits_d[t*CW +: CW]       = ctr_m[t];
                    useful_bits_d[t*UW +: UW]    = useful_m[t];
                    tag_d[t*TW +: TW]            = head.origin_tag[t*TW +: TW];
                    index_d[t*IDX_W +: IDX_W]    = head.index[t*IDX_W +: IDX_W];
                end
            end
            if (alloc) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

`ifdef TAGE_UPDATE_FWD_EN
    // Mirror the table's own saturating update so the next same-index record sees the written value.
    always_comb begin
        fwd_valid_d  = fwd_valid_q;
        fwd_idx_d    = fwd_idx_q;
        fwd_ctr_d    = fwd_ctr_q;
        fwd_useful_d = fwd_useful_q;
        for (int unsigned t = 0; t < NUM_TABLES; t++) begin
            if (update_valid_d[t]) begin
                fwd_valid_d[t] = 1'b1;
                fwd_idx_d[t]   = head.index[t*IDX_W +: IDX_W];
                if (realloc_d[t]) begin
                    fwd_ctr_d[t]    = CTR_REALLOC;
                    fwd_useful_d[t] = '0;
                end else begin
                    fwd_ctr_d[t]    = update_ctr_d[t] ? sat_ctr(ctr_m[t], inc_ctr_d[t]) : ctr_m[t];
                    fwd_useful_d[t] = update_useful_d[t] ? sat_useful(useful_m[t], inc_useful_d[t])
                                                         : useful_m[t];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            ready_q         <= 1'b1;
            lfsr_q          <= 8'hA5;
            update_valid_q  <= '0;
            update_useful_q <= '0;
            inc_useful_q    <= '0;
            update_ctr_q    <= '0;
            inc_ctr_q       <= '0;
            realloc_q       <= '0;
            useful_bits_q   <= '0;
            ctr_bits_q      <= '0;
            tag_q           <= '0;
            index_q         <= '0;
`ifdef TAGE_UPDATE_FWD_EN
            fwd_valid_q     <= '0;
            fwd_idx_q       <= '0;
            fwd_ctr_q       <= '0;
            fwd_useful_q    <= '0;
`endif
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            ready_q         <= ready_d;
            lfsr_q          <= lfsr_d;
            update_valid_q  <= update_valid_d;
            update_useful_q <= update_useful_d;
            inc_useful_q    <= inc_useful_d;
            update_ctr_q    <= update_ctr_d;
            inc_ctr_q       <= inc_ctr_d;
            realloc_q       <= realloc_d;
            useful_bits_q   <= useful_bits_d;
            ctr_bits_q      <= ctr_bits_d;
            tag_q           <= tag_d;
            index_q         <= index_d;
`ifdef TAGE_UPDATE_FWD_EN
            fwd_valid_q     <= fwd_valid_d;
            fwd_idx_q       <= fwd_idx_d;
            fwd_ctr_q       <= fwd_ctr_d;
            fwd_useful_q    <= fwd_useful_d;
`endif
        end
    end

    assign bus.commit_ready_o       = ready_q;
    assign bus.update_valid_o       = update_valid_q;
    assign bus.update_useful_o      = update_useful_q;
    assign bus.inc_useful_o         = inc_useful_q;
    assign bus.update_ctr_o         = update_ctr_q;
    assign bus.inc_ctr_o            = inc_ctr_q;
    assign bus.realloc_entry_o      = realloc_q;
    assign bus.update_useful_bits_o = useful_bits_q;
    assign bus.update_ctr_bits_o    = ctr_bits_q;
    assign bus.update_tag_o         = tag_q;
    assign bus.update_index_o       = index_q;
endmodule
